// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter (5..9 data bits, runtime divisor,
// optional even/odd parity, 1 or 2 stop bits) with a valid/ready frame input.
module uart_tx_cfg #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic [1:0]        parity_mode,
    input  logic              two_stop,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              uart_tx,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int BC_W = 4;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DIV_W-1:0]  r_div;
    logic [DIV_W-1:0]  r_div_cnt;
    logic [BC_W-1:0]   r_bit_cnt;
    logic [DATA_W-1:0] r_data;
    logic              r_par_en;
    logic              r_par_bit;
    logic              r_two_stop;
    logic              r_tx;
    logic              r_busy;
    logic              r_done;

    logic              w_accept;
    logic              w_bit_end;
    logic              w_last_data;
    logic              w_last_stop;
    logic [DIV_W-1:0]  w_div_in;
    logic [DATA_W-1:0] w_data_nxt;
    logic              w_tx_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;

    assign w_accept    = tx_valid && (r_state == S_IDLE);
    assign w_div_in    = (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;
    assign w_bit_end   = (r_state != S_IDLE) &&
                         (r_div_cnt == r_div - DIV_W'(1));
    assign w_last_data = (r_bit_cnt == BC_W'(DATA_W - 1));
    assign w_last_stop = (r_bit_cnt == {{(BC_W-1){1'b0}}, r_two_stop});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:   if (tx_valid) w_state_nxt = S_START;
            S_START:  if (w_bit_end) w_state_nxt = S_DATA;
            S_DATA:
                if (w_bit_end && w_last_data)
                    w_state_nxt = r_par_en ? S_PARITY : S_STOP;
            S_PARITY: if (w_bit_end) w_state_nxt = S_STOP;
            S_STOP:
                if (w_bit_end && w_last_stop) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_data_nxt = r_data;
        if (w_accept)
            w_data_nxt = tx_data;
        else if (r_state == S_DATA && w_bit_end)
            w_data_nxt = r_data >> 1;
    end

    // Outputs are computed from next-state values so they register in step.
    always_comb begin
        w_tx_nxt   = 1'b1;
        w_busy_nxt = 1'b1;
        w_done_nxt = 1'b0;
        unique case (w_state_nxt)
            S_IDLE: begin
                w_busy_nxt = 1'b0;
                w_done_nxt = (r_state == S_STOP);
            end
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = w_data_nxt[0];
            S_PARITY: w_tx_nxt = r_par_bit;
            S_STOP:   w_tx_nxt = 1'b1;
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div      <= '0;
            r_div_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_data     <= '0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_two_stop <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_div      <= w_div_in;
                r_par_en   <= ^parity_mode;
                r_par_bit  <= (^tx_data) ^ parity_mode[1];
                r_two_stop <= two_stop;
            end
            r_data <= w_data_nxt;
            if (r_state == S_IDLE || w_bit_end)
                r_div_cnt <= '0;
            else
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            if (w_state_nxt != r_state)
                r_bit_cnt <= '0;
            else if (w_bit_end)
                r_bit_cnt <= r_bit_cnt + BC_W'(1);
            r_tx   <= w_tx_nxt;
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    assign tx_ready = (r_state == S_IDLE);
    assign uart_tx  = r_tx;
    assign tx_busy  = r_busy;
    assign tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: table-driven frame checks plus back-to-back, divisor
// change and mid-frame reset sequences for uart_tx_cfg.
module tb_uart_tx_cfg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] baud_div;
    logic [1:0]  parity_mode;
    logic        two_stop;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        uart_tx;
    logic        tx_busy;
    logic        tx_done;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0]  data;
        logic [15:0] div;
        logic [1:0]  pm;
        logic        ts;
        logic [12:0] bits;
        int          n;
        int          d;
    } vec_t;

    vec_t tbl[8];

    uart_tx_cfg #(.DATA_W(8), .DIV_W(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .baud_div(baud_div),
        .parity_mode(parity_mode),
        .two_stop(two_stop),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .uart_tx(uart_tx),
        .tx_busy(tx_busy),
        .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic [15:0] div,
                        input logic [1:0] pm, input logic ts);
        for (int i = 0; i < 300 && !tx_ready; i++) @(negedge clk);
        if (!tx_ready) chk("ready_wait", 32'(tx_ready), 32'd1);
        tx_data     = d;
        baud_div    = div;
        parity_mode = pm;
        two_stop    = ts;
        tx_valid    = 1'b1;
        @(negedge clk);
        // Scramble inputs: the frame in flight must keep its latched values.
        tx_valid    = 1'b0;
        tx_data     = ~d;
        baud_div    = 16'd7;
        parity_mode = ~pm;
        two_stop    = ~ts;
    endtask

    // Entered at the START cycle; leaves at the tx_done cycle.
    task automatic check_frame(input string tag, input logic [12:0] bits,
                               input int n, input int d);
        for (int c = 0; c < n * d; c++) begin
            chk($sformatf("%s line c%0d", tag, c), 32'(uart_tx),
                32'(bits[c / d]));
            chk($sformatf("%s busy c%0d", tag, c), 32'(tx_busy), 32'd1);
            chk($sformatf("%s done c%0d", tag, c), 32'(tx_done), 32'd0);
            @(negedge clk);
        end
        chk($sformatf("%s done_pulse", tag), 32'(tx_done), 32'd1);
        chk($sformatf("%s busy_end", tag), 32'(tx_busy), 32'd0);
        chk($sformatf("%s ready_end", tag), 32'(tx_ready), 32'd1);
        chk($sformatf("%s line_end", tag), 32'(uart_tx), 32'd1);
    endtask

    initial begin
        tbl[0] = '{8'h55, 16'd4, 2'b00, 1'b0,
                   13'({1'b1, 8'h55, 1'b0}), 10, 4};
        tbl[1] = '{8'h07, 16'd4, 2'b01, 1'b0,
                   13'({1'b1, 1'b1, 8'h07, 1'b0}), 11, 4};
        tbl[2] = '{8'h07, 16'd4, 2'b10, 1'b0,
                   13'({1'b1, 1'b0, 8'h07, 1'b0}), 11, 4};
        tbl[3] = '{8'hA3, 16'd4, 2'b00, 1'b1,
                   13'({2'b11, 8'hA3, 1'b0}), 11, 4};
        tbl[4] = '{8'h3C, 16'd0, 2'b00, 1'b0,
                   13'({1'b1, 8'h3C, 1'b0}), 10, 2};
        tbl[5] = '{8'hC5, 16'd1, 2'b01, 1'b0,
                   13'({1'b1, 1'b0, 8'hC5, 1'b0}), 11, 2};
        tbl[6] = '{8'h81, 16'd3, 2'b10, 1'b1,
                   13'({2'b11, 1'b1, 8'h81, 1'b0}), 12, 3};
        tbl[7] = '{8'hFF, 16'd2, 2'b11, 1'b0,
                   13'({1'b1, 8'hFF, 1'b0}), 10, 2};

        rst_n       = 1'b0;
        tx_valid    = 1'b0;
        tx_data     = '0;
        baud_div    = 16'd4;
        parity_mode = 2'b00;
        two_stop    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst uart_tx", 32'(uart_tx), 32'd1);
        chk("rst tx_ready", 32'(tx_ready), 32'd1);
        chk("rst tx_busy", 32'(tx_busy), 32'd0);
        chk("rst tx_done", 32'(tx_done), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            send(tbl[v].data, tbl[v].div, tbl[v].pm, tbl[v].ts);
            check_frame($sformatf("v%0d", v), tbl[v].bits,
                        tbl[v].n, tbl[v].d);
            @(negedge clk);
            chk($sformatf("v%0d done_single", v), 32'(tx_done), 32'd0);
            repeat (2) @(negedge clk);
        end

        // Back-to-back with divisor change during the first frame.
        tx_data     = 8'h12;
        baud_div    = 16'd4;
        parity_mode = 2'b00;
        two_stop    = 1'b0;
        tx_valid    = 1'b1;
        @(negedge clk);
        tx_data  = 8'h34;
        baud_div = 16'd8;
        check_frame("b2b1", 13'({1'b1, 8'h12, 1'b0}), 10, 4);
        @(negedge clk);
        tx_valid = 1'b0;
        check_frame("b2b2", 13'({1'b1, 8'h34, 1'b0}), 10, 8);
        repeat (3) @(negedge clk);

        // Reset in the middle of data bit 3 (0x55 bit 3 is 0).
        send(8'h55, 16'd4, 2'b00, 1'b0);
        repeat (17) @(negedge clk);
        chk("pre_rst line", 32'(uart_tx), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst line", 32'(uart_tx), 32'd1);
        chk("mid_rst ready", 32'(tx_ready), 32'd1);
        chk("mid_rst busy", 32'(tx_busy), 32'd0);
        chk("mid_rst done", 32'(tx_done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk($sformatf("post_rst done c%0d", c), 32'(tx_done), 32'd0);
            chk($sformatf("post_rst line c%0d", c), 32'(uart_tx), 32'd1);
        end
        send(8'h96, 16'd4, 2'b01, 1'b0);
        check_frame("post_rst", 13'({1'b1, 1'b0, 8'h96, 1'b0}), 11, 4);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
